// File: rtl/bus_dispatcher_if.sv
// Dispatcher port bundle: config request, input stream, per-column ready and broadcast bus.
// The drop_cnt output is present only when DISPATCH_DROP_CNT_EN is defined.
interface bus_dispatcher_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int ID_W       = $clog2(NUM_COL)
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [NUM_COL*ID_W-1:0]   cfg_tags;
    logic [15:0]               cfg_len;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     in_data;
    logic [ID_W-1:0]           in_id;
    logic [NUM_COL-1:0]        mc_ready;
    logic                      flush;
    logic [NUM_COL*ID_W-1:0]   tag_out;
    logic [DATA_WIDTH-1:0]     bus_data;
    logic [ID_W-1:0]           bus_id;
    logic                      caster_en;
    logic                      done;
`ifdef DISPATCH_DROP_CNT_EN
    logic [7:0]                drop_cnt;

    modport master (
        output cfg_valid, cfg_tags, cfg_len, in_valid, in_data, in_id, mc_ready,
        input  cfg_ready, in_ready, flush, tag_out, bus_data, bus_id, caster_en, done, drop_cnt
    );
    modport slave (
        input  cfg_valid, cfg_tags, cfg_len, in_valid, in_data, in_id, mc_ready,
        output cfg_ready, in_ready, flush, tag_out, bus_data, bus_id, caster_en, done, drop_cnt
    );
`else
    modport master (
        output cfg_valid, cfg_tags, cfg_len, in_valid, in_data, in_id, mc_ready,
        input  cfg_ready, in_ready, flush, tag_out, bus_data, bus_id, caster_en, done
    );
    modport slave (
        input  cfg_valid, cfg_tags, cfg_len, in_valid, in_data, in_id, mc_ready,
        output cfg_ready, in_ready, flush, tag_out, bus_data, bus_id, caster_en, done
    );
`endif
endinterface

// File: rtl/bus_dispatcher.sv
// Tag-flush then broadcast of len words to NUM_COL multicasters; 1-cycle accept-to-bus latency,
// input stalls while any tagged destination column is not ready. DISPATCH_DROP_CNT_EN adds drop_cnt.
module bus_dispatcher #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_COL    = 4,
    localparam int ID_W       = $clog2(NUM_COL)
) (
    input  logic             clk,
    input  logic             rst,
    bus_dispatcher_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [NUM_COL*ID_W-1:0]  tags_q, tags_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic                     cen_q, cen_d;

    logic [NUM_COL-1:0]       match;
    logic                     hit;
    logic                     in_ready;
    logic                     accept;

    always_comb begin
        match = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            match[c] = (tags_q[c*ID_W +: ID_W] == bus.in_id);
        end
    end

    // Unmatched words see an all-ones AND term and are always consumable.
    assign hit      = |match;
    assign in_ready = (state_q == S_STREAM) && (&(bus.mc_ready | ~match));
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        tags_d  = tags_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        id_d    = id_q;
        cen_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    tags_d  = bus.cfg_tags;
                    cnt_d   = bus.cfg_len;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = (cnt_q != 16'd0) ? S_STREAM : S_DONE;
            end
            S_STREAM: begin
                if (accept) begin
                    cnt_d = cnt_q - 16'd1;
                    if (hit) begin
                        cen_d  = 1'b1;
                        data_d = bus.in_data;
                        id_d   = bus.in_id;
                    end
                    if (cnt_q == 16'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tags_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            cen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tags_q  <= tags_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            id_q    <= id_d;
            cen_q   <= cen_d;
        end
    end

    assign bus.cfg_ready = (state_q == S_IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.flush     = (state_q == S_FLUSH);
    assign bus.tag_out   = (state_q == S_FLUSH) ? tags_q : '0;
    assign bus.bus_data  = data_q;
    assign bus.bus_id    = id_q;
    assign bus.caster_en = cen_q;
    assign bus.done      = (state_q == S_DONE);

`ifdef DISPATCH_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (accept && !hit && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_bus_dispatcher.sv
// Directed and randomized passes against a word-level reference model of the dispatcher.
module tb_bus_dispatcher;
    localparam int DW = 16;
    localparam int NC = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_dispatcher_if #(.DATA_WIDTH(DW), .NUM_COL(NC), .ID_W(IW)) bif();
    bus_dispatcher #(.DATA_WIDTH(DW), .NUM_COL(NC)) dut (.clk(clk), .rst(rst), .bus(bif));

    int tests = 0;
    int fails = 0;
    int drops = 0;
    logic [DW-1:0] last_data = '0;
    logic [IW-1:0] last_id   = '0;
    logic [DW-1:0] wq_data[$];
    logic [IW-1:0] wq_id[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit tag_hit(input logic [7:0] tags, input logic [IW-1:0] id);
        for (int c = 0; c < NC; c++) if (tags[c*IW +: IW] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ready_model(input logic [7:0] tags, input logic [IW-1:0] id,
                                       input logic [NC-1:0] mcr);
        for (int c = 0; c < NC; c++) if (tags[c*IW +: IW] == id && !mcr[c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_drop;
`ifdef DISPATCH_DROP_CNT_EN
        chk("drop_cnt", bif.drop_cnt, (drops > 255) ? 255 : drops);
`endif
    endtask

    task automatic start_pass(input logic [7:0] tags, input logic [15:0] len);
        chk("idle_cfg_ready", bif.cfg_ready, 1);
        bif.cfg_valid = 1'b1; bif.cfg_tags = tags; bif.cfg_len = len; bif.in_valid = 1'b1;
        #1;
        chk("idle_in_ready", bif.in_ready, 0);
        tick;
        bif.cfg_valid = 1'b0; bif.cfg_tags = ~tags;
        #1;
        chk("flush_hi", bif.flush, 1);
        chk("flush_tag_out", bif.tag_out, tags);
        chk("flush_cfg_ready", bif.cfg_ready, 0);
        chk("flush_in_ready", bif.in_ready, 0);
        chk("flush_caster_en", bif.caster_en, 0);
        chk("flush_done", bif.done, 0);
        bif.in_valid = 1'b0;
        tick;
        chk("flush_one_cycle", bif.flush, 0);
        chk("flush_tag_out_clr", bif.tag_out, 0);
    endtask

    task automatic run_pass(input logic [7:0] tags, input bit rnd_hs);
        int  len;
        int  acc_n;
        int  budget;
        bit  exp_rdy, acc, hit;
        len = wq_data.size(); acc_n = 0; budget = 0;
        start_pass(tags, 16'(len));
        if (len == 0) begin
            chk("len0_done", bif.done, 1);
            chk("len0_caster_en", bif.caster_en, 0);
            tick;
            chk("len0_done_pulse", bif.done, 0);
            chk("len0_cfg_ready", bif.cfg_ready, 1);
            return;
        end
        while (acc_n < len && budget < 5000) begin
            budget++;
            bif.in_valid  = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            bif.in_data   = wq_data[0];
            bif.in_id     = wq_id[0];
            bif.mc_ready  = (rnd_hs && $urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            bif.cfg_valid = rnd_hs ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            exp_rdy = ready_model(tags, wq_id[0], bif.mc_ready);
            chk("stream_in_ready", bif.in_ready, exp_rdy);
            chk("stream_cfg_ready", bif.cfg_ready, 0);
            acc = bif.in_valid && exp_rdy;
            hit = tag_hit(tags, wq_id[0]);
            tick;
            if (acc) begin
                acc_n++;
                if (hit) begin
                    last_data = wq_data[0];
                    last_id   = wq_id[0];
                end else begin
                    drops++;
                end
                void'(wq_data.pop_front());
                void'(wq_id.pop_front());
            end
            chk("caster_en", bif.caster_en, acc && hit);
            chk("bus_data", bif.bus_data, last_data);
            chk("bus_id", bif.bus_id, last_id);
            chk("done", bif.done, acc_n == len);
            chk("stream_flush", bif.flush, 0);
            check_drop();
        end
        if (acc_n < len) chk("stream_timeout", acc_n, len);
        bif.in_valid = 1'b0; bif.cfg_valid = 1'b0; bif.mc_ready = 4'hF;
        tick;
        chk("post_done", bif.done, 0);
        chk("post_cfg_ready", bif.cfg_ready, 1);
        chk("post_caster_en", bif.caster_en, 0);
    endtask

    initial begin
        logic [7:0] tags;
        rst = 1'b1;
        bif.cfg_valid = 1'b0; bif.cfg_tags = '0; bif.cfg_len = '0;
        bif.in_valid = 1'b0; bif.in_data = '0; bif.in_id = '0; bif.mc_ready = 4'hF;
        #2;
        chk("rst_flush", bif.flush, 0);
        chk("rst_caster_en", bif.caster_en, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_bus_data", bif.bus_data, 0);
        chk("rst_bus_id", bif.bus_id, 0);
        chk("rst_tag_out", bif.tag_out, 0);
        check_drop();
        tick; tick;
        rst = 1'b0;
        tick;

        // Basic three-word broadcast, one column per ID.
        wq_data = '{16'h00A1, 16'h00B2, 16'h00C3}; wq_id = '{2'd1, 2'd2, 2'd3};
        run_pass(8'hE4, 1'b0);

        // Column 1 shares tag 1 and is not ready: the word must wait.
        start_pass(8'b0000_0101, 16'd1);
        bif.in_valid = 1'b1; bif.in_id = 2'd1; bif.in_data = 16'h55AA; bif.mc_ready = 4'b1101;
        #1;
        chk("stall_in_ready", bif.in_ready, 0);
        tick;
        chk("stall_caster_en", bif.caster_en, 0);
        chk("stall_done", bif.done, 0);
        chk("stall_bus_data", bif.bus_data, last_data);
        bif.mc_ready = 4'hF;
        #1;
        chk("unstall_in_ready", bif.in_ready, 1);
        tick;
        last_data = 16'h55AA; last_id = 2'd1;
        chk("unstall_caster_en", bif.caster_en, 1);
        chk("unstall_bus_data", bif.bus_data, last_data);
        chk("unstall_done", bif.done, 1);
        bif.in_valid = 1'b0;
        tick;
        chk("unstall_cfg_ready", bif.cfg_ready, 1);

        // Unmatched ID 3 is consumed but never broadcast.
        wq_data = '{16'h00D3, 16'h00E1}; wq_id = '{2'd3, 2'd1};
        run_pass(8'hA4, 1'b0);

        wq_data.delete(); wq_id.delete();
        run_pass(8'h1B, 1'b0);

        for (int p = 0; p < 8; p++) begin
            int n;
            tags = 8'($urandom);
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                wq_data.push_back(16'($urandom));
                wq_id.push_back(2'($urandom));
            end
            run_pass(tags, 1'b1);
        end

        // All columns tagged 0; IDs 1..3 drive the drop counter past saturation.
        for (int i = 0; i < 300; i++) begin
            wq_data.push_back(16'($urandom));
            wq_id.push_back(2'($urandom_range(1, 3)));
        end
        run_pass(8'h00, 1'b0);
`ifdef DISPATCH_DROP_CNT_EN
        chk("drop_saturated", bif.drop_cnt, 255);
`endif

        // Reset in the middle of a five-word pass.
        for (int i = 0; i < 5; i++) begin
            wq_data.push_back(16'($urandom));
            wq_id.push_back(2'($urandom));
        end
        start_pass(8'hE4, 16'd5);
        for (int i = 0; i < 2; i++) begin
            bif.in_valid = 1'b1; bif.cfg_valid = 1'b1;
            bif.in_data = wq_data[0]; bif.in_id = wq_id[0];
            #1;
            chk("mid_cfg_ready", bif.cfg_ready, 0);
            chk("mid_in_ready", bif.in_ready, 1);
            tick;
            last_data = wq_data.pop_front(); last_id = wq_id.pop_front();
            chk("mid_caster_en", bif.caster_en, 1);
            chk("mid_bus_data", bif.bus_data, last_data);
        end
        bif.in_valid = 1'b0; bif.cfg_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        last_data = '0; last_id = '0; drops = 0;
        chk("arst_flush", bif.flush, 0);
        chk("arst_caster_en", bif.caster_en, 0);
        chk("arst_done", bif.done, 0);
        chk("arst_bus_data", bif.bus_data, 0);
        chk("arst_bus_id", bif.bus_id, 0);
        chk("arst_tag_out", bif.tag_out, 0);
        chk("arst_in_ready", bif.in_ready, 0);
        check_drop();
        tick;
        rst = 1'b0;
        tick;
        chk("rel_cfg_ready", bif.cfg_ready, 1);
        chk("rel_done", bif.done, 0);
        chk("rel_caster_en", bif.caster_en, 0);
        tick;
        chk("rel_done2", bif.done, 0);
        chk("rel_flush2", bif.flush, 0);

        wq_data.delete(); wq_id.delete();
        for (int i = 0; i < 4; i++) begin
            wq_data.push_back(16'($urandom));
            wq_id.push_back(2'($urandom));
        end
        run_pass(8'($urandom), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_dispatcher.md
BUS_DISPATCHER -- requirements
Module: bus_dispatcher

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each broadcast data word.
REQ-002 Parameter NUM_COL, default 4: number of downstream multicasters; ID_W = $clog2(NUM_COL).
REQ-003 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port cfg_valid  input  1: a configuration request is present.
REQ-006 Port cfg_ready  output  1: the dispatcher accepts the configuration.
REQ-007 Port cfg_tags  input  NUM_COL*ID_W: per-column tag; column c uses bits [c*ID_W +: ID_W].
REQ-008 Port cfg_len  input  16: number of data words in the pass.
REQ-009 Port in_valid / in_ready  input / output  1 each: stream handshake.
REQ-010 Port in_data / in_id  input  DATA_WIDTH / ID_W: word and its destination ID.
REQ-011 Port mc_ready  input  NUM_COL: per-multicaster READY.
REQ-012 Port flush  output  1: tag-load strobe to all multicasters.
REQ-013 Port tag_out  output  NUM_COL*ID_W: per-column tags, valid while flush is high.
REQ-014 Port bus_data / bus_id  output  DATA_WIDTH / ID_W: broadcast word and ID.
REQ-015 Port caster_en  output  1: bus_data/bus_id are valid this cycle.
REQ-016 Port done  output  1: one-cycle pulse at the end of a pass.

Function
REQ-017 The FSM SHALL have four states: IDLE, FLUSH, STREAM, DONE.
REQ-018 IDLE: cfg_ready=1; on cfg_valid, latch cfg_tags and cfg_len, then go to FLUSH.
REQ-019 FLUSH: hold for exactly 1 cycle with flush=1 and tag_out=latched tags; go to STREAM if len≠0, else to DONE.
REQ-020 match[c] = (tag[c] == in_id); in_ready SHALL be (state==STREAM) && &(mc_ready | ~match), combinationally.
REQ-021 Accept occurs when in_valid && in_ready; on the next cycle, bus_data/bus_id SHALL equal the accepted word/ID and caster_en=1 (latency 1).
REQ-022 caster_en SHALL be 0 in any cycle that does not follow an accept; bus_data/bus_id SHALL hold their last values.
REQ-023 A word with match==0 (no column tagged with that ID) SHALL still be accepted, SHALL NOT be broadcast (caster_en=0), and SHALL count toward len.
REQ-024 The remaining count SHALL decrement on each accept; an accept at count 1 SHALL move the FSM to DONE.
REQ-025 DONE: done=1 for 1 cycle, then return to IDLE; the last broadcast caster_en coincides with done.
REQ-026 cfg_ready SHALL be 0 outside IDLE; cfg_valid in other states SHALL be ignored.
REQ-027 In_valid outside STREAM SHALL NOT be accepted (in_ready=0).
REQ-028 mc_ready deasserting mid-STREAM SHALL stall acceptance only; no state, count, or output register changes except caster_en falling to 0.

Reset
REQ-029 rst high SHALL immediately force IDLE, count=0, latched tags=0, and outputs flush=0, caster_en=0, done=0, bus_data=0, bus_id=0, tag_out=0.
REQ-030 Reset asserted mid-pass SHALL abandon the pass with no done pulse; the first cycle after release is IDLE with cfg_ready=1.

Configuration
REQ-031 Macro DISPATCH_DROP_CNT_EN defined: an extra output drop_cnt (8 bits) counts REQ-023 unmatched accepts, saturates at 255, and clears only on rst.
REQ-032 Macro DISPATCH_DROP_CNT_EN undefined: the drop_cnt port and counter are absent; unmatched words are still consumed silently.

Verification
REQ-033 Stimulus: NUM_COL=4, tags {0,1,2,3}, len=3, words 0xA1/0xB2/0xC3 with IDs 1/2/3, mc_ready=4'hF. Required: flush for 1 cycle, three consecutive caster_en cycles each one cycle after its accept, done coincident with the third.
REQ-034 Stimulus: tags {1,1,0,0}, in_id=1, mc_ready=4'b1101. Required: in_ready=0; then mc_ready=4'hF gives accept and, one cycle later, caster_en=1.
REQ-035 Stimulus: len=2, word with ID 3 while no column is tagged 3. Required: word accepted, caster_en=0, count decrements; with the macro defined, drop_cnt=1.
REQ-036 Stimulus: len=0. Required: IDLE→FLUSH→DONE, done pulses on cycle 2, no caster_en.
REQ-037 Stimulus: rst pulse after 2 of 5 words. Required: all outputs 0 immediately, no done, cfg_ready=1 after release; cfg_valid during STREAM is never acknowledged.
REQ-038 Stimulus: 300 unmatched words with the macro defined. Required: drop_cnt saturates at 255.
